// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : EX/MEM-side bus bundle for the memory stage. Carries the
//                control strobes, address, store data and link value in,
//                and returns load data and the writeback value.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if;
  logic        MemWr;
  logic        MemRd;
  logic [1:0]  MemToReg;
  logic [31:0] ALUResult;
  logic [31:0] ReadData2;
  logic [31:0] NextPC;
  logic [31:0] ReadData;
  logic [31:0] WriteBackData;

  // Pipeline register side: drives the request, consumes the results
  modport master (
    output MemWr, MemRd, MemToReg, ALUResult, ReadData2, NextPC,
    input  ReadData, WriteBackData
  );

  // Memory stage side
  modport slave (
    input  MemWr, MemRd, MemToReg, ALUResult, ReadData2, NextPC,
    output ReadData, WriteBackData
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory stage. Word-addressed data RAM plus a small
//                memory-mapped peripheral block (timer, LEDs, switches,
//                seven-segment, free-running systick) and writeback select.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int RAM_WORDS = 256
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mem_stage_if.slave       bus,
  input  wire logic [7:0]  switch,
  output logic      [7:0]  led,
  output logic      [11:0] digi,
  output logic             irqout
);

  localparam int          AW          = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [29:0] c_RAM_WORDS = 30'(RAM_WORDS);
  // 0x40000000 >> 5: the peripheral window spans eight word slots
  localparam logic [26:0] c_IO_BASE   = 27'h200_0000;

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [7:0]  r_led;
  logic [11:0] r_digi;
  logic [31:0] r_systick;

  logic          w_is_ram;
  logic          w_is_io;
  logic [2:0]    w_io_sel;
  logic [AW-1:0] w_ram_idx;
  logic [31:0]   w_rdata;
  logic          w_wr_th;
  logic          w_wr_tl;
  logic          w_wr_tcon;
  logic          w_wr_led;
  logic          w_wr_digi;

  // Byte offset within the word is ignored: all accesses are whole words
  assign w_is_ram  = (bus.ALUResult[31:2] < c_RAM_WORDS);
  assign w_is_io   = (bus.ALUResult[31:5] == c_IO_BASE);
  assign w_io_sel  = bus.ALUResult[4:2];
  assign w_ram_idx = bus.ALUResult[AW+1:2];

  assign w_wr_th   = bus.MemWr && w_is_io && (w_io_sel == 3'd0);
  assign w_wr_tl   = bus.MemWr && w_is_io && (w_io_sel == 3'd1);
  assign w_wr_tcon = bus.MemWr && w_is_io && (w_io_sel == 3'd2);
  assign w_wr_led  = bus.MemWr && w_is_io && (w_io_sel == 3'd3);
  assign w_wr_digi = bus.MemWr && w_is_io && (w_io_sel == 3'd5);

  // Load path: read before any same-cycle store lands, zero when unmapped
  always_comb begin
    w_rdata = 32'd0;
    if (w_is_ram) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_is_io) begin
      case (w_io_sel)
        3'd0:    w_rdata = r_th;
        3'd1:    w_rdata = r_tl;
        3'd2:    w_rdata = {29'd0, r_tcon};
        3'd3:    w_rdata = {24'd0, r_led};
        3'd4:    w_rdata = {24'd0, switch};
        3'd5:    w_rdata = {20'd0, r_digi};
        3'd6:    w_rdata = r_systick;
        default: w_rdata = 32'd0;
      endcase
    end
    bus.ReadData = bus.MemRd ? w_rdata : 32'd0;
  end

  // Writeback select toward the MEM/WB register
  always_comb begin
    case (bus.MemToReg)
      2'b00:   bus.WriteBackData = bus.ALUResult;
      2'b01:   bus.WriteBackData = bus.ReadData;
      2'b10:   bus.WriteBackData = bus.NextPC;
      default: bus.WriteBackData = 32'd0;
    endcase
  end

  // Data RAM: no reset, contents persist across reset
  always_ff @(posedge clk) begin
    if (bus.MemWr && w_is_ram) begin
      r_ram[w_ram_idx] <= bus.ReadData2;
    end
  end

  // Peripheral registers: timer update first, stores afterwards so they win
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th      <= 32'd0;
      r_tl      <= 32'd0;
      r_tcon    <= 3'b000;
      r_led     <= 8'd0;
      r_digi    <= 12'd0;
      r_systick <= 32'd0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (r_tcon[0]) begin
        if (r_tl == 32'hFFFF_FFFF) begin
          r_tl <= r_th;
          if (r_tcon[1]) begin
            r_tcon[2] <= 1'b1;
          end
        end else begin
          r_tl <= r_tl + 32'd1;
        end
      end
      if (w_wr_th)   r_th   <= bus.ReadData2;
      if (w_wr_tl)   r_tl   <= bus.ReadData2;
      if (w_wr_tcon) r_tcon <= bus.ReadData2[2:0];
      if (w_wr_led)  r_led  <= bus.ReadData2[7:0];
      if (w_wr_digi) r_digi <= bus.ReadData2[11:0];
    end
  end

  assign led    = r_led;
  assign digi   = r_digi;
  assign irqout = r_tcon[2];

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter RAM_WORDS, default 256, meaning data RAM depth in 32-bit words; power of two, at most 256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; all registers below reset immediately while low.
REQ-004 MemWr  input  1  store strobe from EX/MEM register.
REQ-005 MemRd  input  1  load strobe from EX/MEM register.
REQ-006 MemToReg  input  2  writeback select from EX/MEM register.
REQ-007 ALUResult  input  32  byte address for loads/stores; also ALU writeback value.
REQ-008 ReadData2  input  32  store data.
REQ-009 NextPC  input  32  link value (PC+4) for jal/jalr writeback.
REQ-010 switch  input  8  board switches, read-only peripheral.
REQ-011 ReadData  output  32  load data, combinational.
REQ-012 WriteBackData  output  32  value forwarded to MEM/WB register, combinational.
REQ-013 led  output  8  LED register.
REQ-014 digi  output  12  seven-segment register.
REQ-015 irqout  output  1  timer interrupt request, equals TCON[2].

Function
REQ-016 Address decode SHALL use ALUResult with bits [1:0] ignored (word access only).
REQ-017 Map: 0x00000000..(RAM_WORDS*4-1) RAM indexed by ALUResult[9:2]; 0x40000000 TH; 0x40000004 TL; 0x40000008 TCON[2:0]; 0x4000000C led; 0x40000010 switch (RO); 0x40000014 digi; 0x40000018 systick (RO).
REQ-018 ReadData SHALL equal the addressed location zero-extended when MemRd=1, and 0 when MemRd=0 or the address is unmapped.
REQ-019 Stores SHALL commit on the rising edge when MemWr=1; writes to RO or unmapped addresses SHALL be ignored.
REQ-020 A load and a store to the same address in the same cycle SHALL return the pre-write value.
REQ-021 WriteBackData: MemToReg=00 -> ALUResult; 01 -> ReadData; 10 -> NextPC; 11 -> 0.
REQ-022 systick SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF -> 0.
REQ-023 Timer, when TCON[0]=1: if TL=0xFFFFFFFF then TL<=TH and, if TCON[1]=1, TCON[2]<=1; else TL<=TL+1.
REQ-024 Timer, when TCON[0]=0: TL and TCON[2] SHALL hold.
REQ-025 A store to TL, TH or TCON in the same cycle as a timer update to that register SHALL take priority (written value lands, increment/set lost for that register).
REQ-026 TCON[2] SHALL be cleared only by a store writing 0 to bit 2 or by reset; it is sticky otherwise.
REQ-027 Writes to TCON SHALL affect bits [2:0] only; reads SHALL return {29'b0, TCON}.
REQ-028 led and digi SHALL take ReadData2[7:0] and ReadData2[11:0] respectively on store; reads return them zero-extended.
REQ-029 Stage latency: loads combinational within cycle; stores and peripheral effects visible from the next cycle.

Reset
REQ-030 While reset=0: TH, TL, systick = 0; TCON = 3'b000; led = 0; digi = 0; irqout = 0.
REQ-031 RAM contents SHALL NOT be cleared by reset and are undefined until written.
REQ-032 Reset asserted mid-operation SHALL abort any pending timer event; first count after release occurs on the first rising edge with reset=1.

Verification
REQ-033 Store 0xDEADBEEF to 0x00000010, next cycle load 0x00000013 with MemToReg=01 -> ReadData=WriteBackData=0xDEADBEEF.
REQ-034 TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3'b011 -> two cycles later TL=0xFFFFFFF0, irqout=1; store TCON=3'b011 -> irqout=0 next cycle.
REQ-035 Store TL=5 while timer enabled and TL=0xFFFFFFFF -> TL=5, irqout unchanged.
REQ-036 switch=0xA5, load 0x40000010 -> ReadData=0x000000A5; store 0x12 there -> no state change; load 0x50000000 -> 0.
REQ-037 MemToReg=10, NextPC=0x00400008 -> WriteBackData=0x00400008; MemToReg=00, ALUResult=0x1234 -> 0x1234.
REQ-038 Assert reset mid-count with led=0xFF, TCON=3'b111 -> all outputs 0 immediately, without waiting for clk.
